// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: load-type encodings and register constants.
package mips_defs;

  localparam int unsigned LOAD_TYPE_W = 3;
  localparam int unsigned REG_ADDR_W  = 5;

  localparam logic [LOAD_TYPE_W-1:0] LOAD_LW  = 3'd0;
  localparam logic [LOAD_TYPE_W-1:0] LOAD_LH  = 3'd1;
  localparam logic [LOAD_TYPE_W-1:0] LOAD_LHU = 3'd2;
  localparam logic [LOAD_TYPE_W-1:0] LOAD_LB  = 3'd3;
  localparam logic [LOAD_TYPE_W-1:0] LOAD_LBU = 3'd4;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_extract.sv
// Little-endian sub-word load extraction with alignment check.
module load_extract
  import mips_defs::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]      word,
  input  logic [1:0]             addr,
  input  logic [LOAD_TYPE_W-1:0] load_type,
  output logic [DATA_W-1:0]      data,
  output logic                   misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    unique case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  // Encodings 5-7 fall through to full-word behaviour.
  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (load_type)
      LOAD_LB: data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
      LOAD_LH: begin
        data       = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LOAD_LHU: begin
        data       = {{(DATA_W-16){1'b0}}, half_sel};
        misaligned = addr[0];
      end
      default: begin
        data       = word;
        misaligned = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back select, retire counter and sticky misaligned-load flag.
module mem_wb_stage
  import mips_defs::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [2:0]            load_type_in,
  input  logic                  err_clr_in,
  output logic                  valid_out,
  output logic                  reg_write_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic [DATA_W-1:0]     write_data_out,
  output logic                  misalign_err,
  output logic [DATA_W-1:0]     misalign_addr,
  output logic [31:0]           retired_count
);

  localparam int unsigned CNT_W = 32;

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     mem_data_q, mem_data_d;
  logic [DATA_W-1:0]     alu_result_q, alu_result_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [2:0]            load_type_q, load_type_d;
  logic                  misalign_err_q, misalign_err_d;
  logic [DATA_W-1:0]     misalign_addr_q, misalign_addr_d;
  logic [CNT_W-1:0]      retired_count_q, retired_count_d;

  logic [DATA_W-1:0]     load_data;
  logic                  load_misaligned;
  logic                  misaligned;
  logic                  err_set;
  logic                  capture;

  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .word       (mem_data_q),
    .addr       (alu_result_q[1:0]),
    .load_type  (load_type_q),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  assign misaligned = mem_to_reg_q & load_misaligned;
  assign err_set    = valid_q & misaligned;
  assign capture    = !flush_in && !stall_in;

  // Pipeline capture: flush beats stall, stall holds everything.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    write_reg_d  = write_reg_q;
    mem_data_d   = mem_data_q;
    alu_result_d = alu_result_q;
    mem_to_reg_d = mem_to_reg_q;
    load_type_d  = load_type_q;
    if (flush_in) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall_in) begin
      valid_d      = valid_in;
      reg_write_d  = reg_write_in;
      write_reg_d  = write_reg_in;
      mem_data_d   = mem_data_in;
      alu_result_d = alu_result_in;
      mem_to_reg_d = mem_to_reg_in;
      load_type_d  = load_type_in;
    end
  end

  // First error since clear keeps its address; a new set outranks a clear.
  always_comb begin
    misalign_err_d  = misalign_err_q;
    misalign_addr_d = misalign_addr_q;
    if (err_set) begin
      misalign_err_d = 1'b1;
      if (!misalign_err_q || err_clr_in) begin
        misalign_addr_d = alu_result_q;
      end
    end else if (err_clr_in) begin
      misalign_err_d  = 1'b0;
      misalign_addr_d = '0;
    end
  end

  always_comb begin
    retired_count_d = retired_count_q;
    if (capture && valid_in) begin
      retired_count_d = retired_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      write_reg_q     <= '0;
      mem_data_q      <= '0;
      alu_result_q    <= '0;
      mem_to_reg_q    <= 1'b0;
      load_type_q     <= '0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
      retired_count_q <= '0;
    end else begin
      valid_q         <= valid_d;
      reg_write_q     <= reg_write_d;
      write_reg_q     <= write_reg_d;
      mem_data_q      <= mem_data_d;
      alu_result_q    <= alu_result_d;
      mem_to_reg_q    <= mem_to_reg_d;
      load_type_q     <= load_type_d;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign valid_out      = valid_q;
  assign reg_write_out  = valid_q & reg_write_q & (write_reg_q != REG_ZERO) & !misaligned;
  assign write_reg_out  = write_reg_q;
  assign write_data_out = mem_to_reg_q ? load_data : alu_result_q;
  assign misalign_err   = misalign_err_q;
  assign misalign_addr  = misalign_addr_q;
  assign retired_count  = retired_count_q;

endmodule
